// File: rtl/eth_pkg.sv
// Shared encodings and frame-layout constants for the RMII receive-frame controller.
package eth_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA
    } rx_state_t;

    typedef enum logic [2:0] {
        B_IDLE,
        B_DEST_ADDR,
        B_SRC_ADDR,
        B_LEN_TYPE,
        B_PAYLOAD,
        B_DROP,
        B_CHECK
    } byte_state_t;

    localparam int ST_CRC_ERR  = 0;
    localparam int ST_RUNT     = 1;
    localparam int ST_GIANT    = 2;
    localparam int ST_FILTERED = 3;

    localparam int DEST_BYTES = 6;
    localparam int SRC_BYTES  = 6;
    localparam int TYPE_BYTES = 2;
    localparam int HDR_BYTES  = DEST_BYTES + SRC_BYTES + TYPE_BYTES;
    localparam int FCS_BYTES  = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_delay.sv
// Four-byte delay line: holds back the trailing FCS so only frame data reaches the CRC engine.
module eth_rx_fcs_delay (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic        o_dly_vld,
    output logic [7:0]  o_dly_byte,
    output logic [2:0]  o_fill,
    output logic [31:0] o_fcs
);
    import eth_pkg::*;

    logic [7:0] r_sh [FCS_BYTES];
    logic [2:0] r_fill;
    logic       r_vld;
    logic [7:0] r_byte;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill <= 3'd0;
            r_vld  <= 1'b0;
            r_byte <= 8'd0;
            for (int i = 0; i < FCS_BYTES; i++) r_sh[i] <= 8'd0;
        end else if (i_clr) begin
            r_fill <= 3'd0;
            r_vld  <= 1'b0;
            for (int i = 0; i < FCS_BYTES; i++) r_sh[i] <= 8'd0;
        end else begin
            r_vld <= 1'b0;
            if (i_load) begin
                if (r_fill == 3'(FCS_BYTES)) begin
                    r_vld  <= 1'b1;
                    r_byte <= r_sh[FCS_BYTES-1];
                end else begin
                    r_fill <= r_fill + 3'd1;
                end
                r_sh[0] <= i_byte;
                for (int i = 1; i < FCS_BYTES; i++) r_sh[i] <= r_sh[i-1];
            end
        end
    end

    // Oldest held byte is FCS byte 0, so it lands in the LSBs.
    assign o_fcs      = {r_sh[0], r_sh[1], r_sh[2], r_sh[3]};
    assign o_dly_vld  = r_vld;
    assign o_dly_byte = r_byte;
    assign o_fill     = r_fill;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// RMII receive-frame controller: preamble/SFD detection, header parse and filter,
// FCS strip and check, length limits and per-frame status reporting.
module eth_rx_frame_ctrl #(
    parameter int          pPreamble_Dibits = 31,
    parameter logic [47:0] pMAC_Addr        = 48'h02_00_00_00_00_01,
    parameter bit          pPromisc         = 1'b0,
    parameter bit          pAccept_Bcast    = 1'b1,
    parameter int          pNum_Types       = 2,
    parameter logic [16*((pNum_Types > 0) ? pNum_Types : 1)-1:0] pLen_Types = {16'h0800, 16'h0806},
    parameter int          pMin_Frame_Bytes = 64,
    parameter int          pMax_Frame_Bytes = 1518,
    parameter int          pCrc_Latency     = 1
) (
    input  logic        Clk,
    input  logic        Rst_N,
    input  logic        Crs_Dv,
    input  logic [1:0]  Rxd,
    input  logic        Byte_Rdy,
    input  logic [7:0]  Byte,
    input  logic [31:0] Crc_Computed,
    output logic        Rx_En,
    output logic        Crc_Rst,
    output logic        Crc_Byte_Vld,
    output logic [7:0]  Crc_Byte,
    output logic        Payload_Vld,
    output logic [7:0]  Payload_Byte,
    output logic [15:0] Len_Type,
    output logic        Frame_Done,
    output logic        Frame_Good,
    output logic [3:0]  Frame_Status,
    output logic [15:0] Frame_Bytes
);
    import eth_pkg::*;

    localparam int          NT        = (pNum_Types > 0) ? pNum_Types : 1;
    localparam logic [7:0]  PRE_N     = 8'(pPreamble_Dibits);
    localparam logic [15:0] MIN_B     = 16'(pMin_Frame_Bytes);
    localparam logic [15:0] MAX_B     = 16'(pMax_Frame_Bytes);
    localparam logic [15:0] PAY_START = 16'(HDR_BYTES + FCS_BYTES);
    localparam logic [7:0]  CRC_LAT   = 8'(pCrc_Latency);

    rx_state_t   r_rx_state;
    logic [7:0]  r_dibit_cnt;
    logic        r_rx_en;
    logic        r_crc_rst;

    byte_state_t r_by_state;
    logic [15:0] r_byte_cnt;
    logic [39:0] r_dest;
    logic [15:0] r_len_type;
    logic        r_filt;
    logic        r_giant;
    logic        r_pay_gate;
    logic [7:0]  r_wait;
    logic        r_done;
    logic        r_good;
    logic [3:0]  r_status;
    logic [15:0] r_bytes;

    logic        w_sof, w_eof, w_acc, w_giant_now, w_pay;
    logic [47:0] w_dest_full;
    logic        w_dest_ok, w_type_ok;
    logic        w_dly_vld;
    logic [7:0]  w_dly_byte;
    logic [2:0]  w_fill;
    logic [31:0] w_fcs;
    logic [3:0]  w_status;

    function automatic logic type_match(input logic [15:0] t);
        logic m;
        m = (pNum_Types == 0);
        for (int k = 0; k < NT; k++)
            if (pNum_Types > 0 && pLen_Types[16*k +: 16] == t) m = 1'b1;
        return m;
    endfunction

    // A new SFD is only taken once the previous frame has reported its status.
    assign w_sof = (r_rx_state == RX_PREAMBLE) && Crs_Dv && (Rxd == 2'b11) &&
                   (r_dibit_cnt == PRE_N) && (r_by_state == B_IDLE);
    assign w_eof = (r_rx_state == RX_DATA) && !Crs_Dv;
    assign w_acc = Byte_Rdy && (r_rx_state == RX_DATA);
    assign w_giant_now = w_acc && (r_byte_cnt >= MAX_B);

    assign w_dest_full = {r_dest, Byte};
    assign w_dest_ok   = pPromisc || (w_dest_full == pMAC_Addr) || (pAccept_Bcast && (&w_dest_full));
    assign w_type_ok   = type_match({r_len_type[7:0], Byte});

    assign w_pay = w_acc && (r_by_state == B_PAYLOAD) && !w_giant_now &&
                   (w_fill == 3'(FCS_BYTES)) && (r_byte_cnt >= PAY_START);

    always_comb begin
        w_status = 4'd0;
        w_status[ST_CRC_ERR]  = (w_fcs != Crc_Computed) || (r_byte_cnt < 16'(FCS_BYTES));
        w_status[ST_RUNT]     = r_byte_cnt < MIN_B;
        w_status[ST_GIANT]    = r_giant;
        w_status[ST_FILTERED] = r_filt;
    end

    eth_rx_fcs_delay u_fcs_delay (
        .i_clk      (Clk),
        .i_rst_n    (Rst_N),
        .i_clr      (w_sof),
        .i_load     (w_acc),
        .i_byte     (Byte),
        .o_dly_vld  (w_dly_vld),
        .o_dly_byte (w_dly_byte),
        .o_fill     (w_fill),
        .o_fcs      (w_fcs)
    );

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_rx_state  <= RX_IDLE;
            r_dibit_cnt <= 8'd0;
            r_rx_en     <= 1'b0;
            r_crc_rst   <= 1'b0;
        end else begin
            r_crc_rst <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (Crs_Dv && Rxd == 2'b01) begin
                        r_rx_state  <= RX_PREAMBLE;
                        r_dibit_cnt <= 8'd1;
                    end
                end
                RX_PREAMBLE: begin
                    if (w_sof) begin
                        r_rx_state <= RX_DATA;
                        r_rx_en    <= 1'b1;
                        r_crc_rst  <= 1'b1;
                    end else if (!Crs_Dv) begin
                        r_rx_state <= RX_IDLE;
                    end else if (Rxd == 2'b01) begin
                        if (r_dibit_cnt != 8'hFF) r_dibit_cnt <= r_dibit_cnt + 8'd1;
                    end else if (!(Rxd == 2'b11 && r_dibit_cnt == PRE_N)) begin
                        r_rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!Crs_Dv) begin
                        r_rx_state <= RX_IDLE;
                        r_rx_en    <= 1'b0;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_by_state <= B_IDLE;
            r_byte_cnt <= 16'd0;
            r_dest     <= 40'd0;
            r_len_type <= 16'd0;
            r_filt     <= 1'b0;
            r_giant    <= 1'b0;
            r_pay_gate <= 1'b0;
            r_wait     <= 8'd0;
            r_done     <= 1'b0;
            r_good     <= 1'b0;
            r_status   <= 4'd0;
            r_bytes    <= 16'd0;
        end else begin
            r_done     <= 1'b0;
            r_pay_gate <= w_pay;
            if (w_acc) r_byte_cnt <= sat_inc16(r_byte_cnt);
            if (w_giant_now) r_giant <= 1'b1;
            case (r_by_state)
                B_IDLE: begin
                    if (w_sof) begin
                        r_by_state <= B_DEST_ADDR;
                        r_byte_cnt <= 16'd0;
                        r_dest     <= 40'd0;
                        r_len_type <= 16'd0;
                        r_filt     <= 1'b0;
                        r_giant    <= 1'b0;
                    end
                end
                B_DEST_ADDR: begin
                    if (w_acc) begin
                        r_dest <= {r_dest[31:0], Byte};
                        if (r_byte_cnt == 16'(DEST_BYTES-1)) begin
                            if (w_dest_ok) begin
                                r_by_state <= B_SRC_ADDR;
                            end else begin
                                r_filt     <= 1'b1;
                                r_by_state <= B_DROP;
                            end
                        end
                    end
                end
                B_SRC_ADDR: begin
                    if (w_acc && r_byte_cnt == 16'(DEST_BYTES+SRC_BYTES-1)) r_by_state <= B_LEN_TYPE;
                end
                B_LEN_TYPE: begin
                    if (w_acc) begin
                        r_len_type <= {r_len_type[7:0], Byte};
                        if (r_byte_cnt == 16'(HDR_BYTES-1)) begin
                            if (w_type_ok) begin
                                r_by_state <= B_PAYLOAD;
                            end else begin
                                r_filt     <= 1'b1;
                                r_by_state <= B_DROP;
                            end
                        end
                    end
                end
                B_PAYLOAD, B_DROP: begin
                end
                B_CHECK: begin
                    if (r_wait == CRC_LAT) begin
                        r_done     <= 1'b1;
                        r_status   <= w_status;
                        r_good     <= (w_status == 4'd0);
                        r_bytes    <= r_byte_cnt;
                        r_by_state <= B_IDLE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_by_state <= B_IDLE;
            endcase
            if (w_giant_now) r_by_state <= B_DROP;
            // End of frame wins over every parse decision made on the same cycle.
            if (w_eof && r_by_state != B_IDLE && r_by_state != B_CHECK) begin
                r_by_state <= B_CHECK;
                r_wait     <= 8'd0;
            end
        end
    end

    assign Rx_En        = r_rx_en;
    assign Crc_Rst      = r_crc_rst;
    assign Crc_Byte_Vld = w_dly_vld;
    assign Crc_Byte     = w_dly_byte;
    assign Payload_Vld  = w_dly_vld & r_pay_gate;
    assign Payload_Byte = Payload_Vld ? w_dly_byte : 8'd0;
    assign Len_Type     = r_len_type;
    assign Frame_Done   = r_done;
    assign Frame_Good   = r_good;
    assign Frame_Status = r_status;
    assign Frame_Bytes  = r_bytes;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Self-checking bench for eth_rx_frame_ctrl with dibit assembler and CRC-32 engine models.
module tb_eth_rx_frame_ctrl;

    logic        Clk;
    logic        Rst_N;
    logic        Crs_Dv;
    logic [1:0]  Rxd;
    logic        Byte_Rdy;
    logic [7:0]  Byte;
    logic [31:0] Crc_Computed;
    logic        Rx_En, Crc_Rst, Crc_Byte_Vld, Payload_Vld, Frame_Done, Frame_Good;
    logic [7:0]  Crc_Byte, Payload_Byte;
    logic [15:0] Len_Type, Frame_Bytes;
    logic [3:0]  Frame_Status;

    localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    eth_rx_frame_ctrl dut (
        .Clk(Clk), .Rst_N(Rst_N), .Crs_Dv(Crs_Dv), .Rxd(Rxd),
        .Byte_Rdy(Byte_Rdy), .Byte(Byte), .Crc_Computed(Crc_Computed),
        .Rx_En(Rx_En), .Crc_Rst(Crc_Rst), .Crc_Byte_Vld(Crc_Byte_Vld), .Crc_Byte(Crc_Byte),
        .Payload_Vld(Payload_Vld), .Payload_Byte(Payload_Byte), .Len_Type(Len_Type),
        .Frame_Done(Frame_Done), .Frame_Good(Frame_Good), .Frame_Status(Frame_Status),
        .Frame_Bytes(Frame_Bytes)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Dibit-to-byte assembler, LSB dibit first.
    logic [7:0] asm_sh;
    int         asm_n;
    always @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            asm_n <= 0; asm_sh <= 8'd0; Byte_Rdy <= 1'b0; Byte <= 8'd0;
        end else begin
            Byte_Rdy <= 1'b0;
            if (Rx_En && Crs_Dv) begin
                asm_sh <= {Rxd, asm_sh[7:2]};
                if (asm_n == 3) begin
                    Byte <= {Rxd, asm_sh[7:2]}; Byte_Rdy <= 1'b1; asm_n <= 0;
                end else asm_n <= asm_n + 1;
            end else asm_n <= 0;
        end
    end

    // CRC-32 engine, one cycle of latency after each strobe.
    logic [31:0] crc_q;
    always @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N)            crc_q <= 32'hFFFFFFFF;
        else if (Crc_Rst)      crc_q <= 32'hFFFFFFFF;
        else if (Crc_Byte_Vld) crc_q <= crc_upd(crc_q, Crc_Byte);
    end
    assign Crc_Computed = ~crc_q;

    typedef struct {
        int          len;
        logic [47:0] dest;
        logic [15:0] etype;
        bit          corrupt;
        logic [3:0]  exp_status;
        int          exp_pay;
    } vec_t;

    typedef struct {
        logic [3:0]  status;
        int          bytes;
        int          pay;
        int          crcv;
        bit          chk_lt;
        logic [15:0] lt;
    } exp_t;

    vec_t       vt [9];
    exp_t       sb_q [$];
    logic [7:0] pay_q [$];
    logic [7:0] fb [0:1599];

    int n_checks = 0, n_errors = 0;
    int n_crcv = 0, n_pay = 0, n_crst = 0, n_done = 0;
    bit mon_en = 1'b1;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_t       r;
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            if (Crc_Rst) begin n_crcv = 0; n_pay = 0; n_crst++; end
            if (Crc_Byte_Vld) n_crcv++;
            if (Payload_Vld && mon_en) begin
                n_pay++;
                if (pay_q.size() == 0) chk("payload_unexpected", 48'(pay_q.size()), 48'd1);
                else begin
                    e = pay_q.pop_front();
                    chk("payload_byte", 48'(Payload_Byte), 48'(e));
                end
            end
            if (Frame_Done) begin
                n_done++;
                if (sb_q.size() == 0) chk("done_unexpected", 48'(sb_q.size()), 48'd1);
                else begin
                    r = sb_q.pop_front();
                    chk("frame_status", 48'(Frame_Status), 48'(r.status));
                    chk("frame_good", 48'(Frame_Good), 48'(r.status == 4'd0));
                    chk("frame_bytes", 48'(Frame_Bytes), 48'(r.bytes));
                    chk("payload_count", 48'(n_pay), 48'(r.pay));
                    chk("crc_vld_count", 48'(n_crcv), 48'(r.crcv));
                    if (r.chk_lt) chk("len_type", 48'(Len_Type), 48'(r.lt));
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk); #1;
    endtask

    task automatic build(input int len, input logic [47:0] dest, input logic [15:0] et,
                         input bit corrupt, input int seed);
        logic [31:0] c;
        for (int k = 0; k < len; k++) fb[k] = 8'((k * 7 + seed * 13 + 5) & 255);
        for (int k = 0; k < 6; k++) fb[k] = dest[47-8*k -: 8];
        for (int k = 6; k < 12; k++) fb[k] = 8'(16 + k);
        fb[12] = et[15:8];
        fb[13] = et[7:0];
        c = 32'hFFFFFFFF;
        for (int k = 0; k < len - 4; k++) c = crc_upd(c, fb[k]);
        c = ~c;
        for (int k = 0; k < 4; k++) fb[len-4+k] = c[8*k +: 8];
        if (corrupt) fb[len-4] = fb[len-4] ^ 8'h01;
    endtask

    task automatic drive_preamble(input int n);
        for (int k = 0; k < n; k++) begin Crs_Dv = 1'b1; Rxd = 2'b01; step(); end
    endtask

    task automatic drive_bytes(input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = fb[k];
            for (int d = 0; d < 4; d++) begin Rxd = b[2*d +: 2]; step(); end
        end
    endtask

    task automatic send_frame(input int len);
        drive_preamble(31);
        Rxd = 2'b11; step();
        drive_bytes(len);
        Crs_Dv = 1'b0; Rxd = 2'b00;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb_q.size() > 0 && t < 100) begin @(posedge Clk); t++; end
        #1;
        if (sb_q.size() > 0) begin
            chk("frame_done_timeout", 48'(sb_q.size()), 48'd0);
            sb_q.delete();
        end
        chk("payload_drained", 48'(pay_q.size()), 48'd0);
        pay_q.delete();
        repeat (12) step();
    endtask

    task automatic run_vec(input int i);
        exp_t x;
        build(vt[i].len, vt[i].dest, vt[i].etype, vt[i].corrupt, i);
        x.status = vt[i].exp_status;
        x.bytes  = vt[i].len;
        x.pay    = vt[i].exp_pay;
        x.crcv   = vt[i].len - 4;
        x.chk_lt = vt[i].exp_pay > 0;
        x.lt     = vt[i].etype;
        sb_q.push_back(x);
        for (int k = 14; k < 14 + vt[i].exp_pay; k++) pay_q.push_back(fb[k]);
        send_frame(vt[i].len);
        wait_done();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_en"}, 48'(Rx_En), 48'd0);
        chk({tag, "_crc_rst"}, 48'(Crc_Rst), 48'd0);
        chk({tag, "_crc_vld"}, 48'(Crc_Byte_Vld), 48'd0);
        chk({tag, "_crc_byte"}, 48'(Crc_Byte), 48'd0);
        chk({tag, "_pay_vld"}, 48'(Payload_Vld), 48'd0);
        chk({tag, "_len_type"}, 48'(Len_Type), 48'd0);
        chk({tag, "_done"}, 48'(Frame_Done), 48'd0);
        chk({tag, "_good"}, 48'(Frame_Good), 48'd0);
        chk({tag, "_status"}, 48'(Frame_Status), 48'd0);
        chk({tag, "_bytes"}, 48'(Frame_Bytes), 48'd0);
    endtask

    initial begin
        int crst0, done0;
        vt[0] = '{64,   MAC,   16'h0800, 1'b0, 4'b0000, 46};
        vt[1] = '{64,   MAC,   16'h0800, 1'b1, 4'b0001, 46};
        vt[2] = '{64,   OTHER, 16'h0800, 1'b0, 4'b1000, 0};
        vt[3] = '{64,   BCAST, 16'h0806, 1'b0, 4'b0000, 46};
        vt[4] = '{64,   MAC,   16'h86DD, 1'b0, 4'b1000, 0};
        vt[5] = '{40,   MAC,   16'h0800, 1'b0, 4'b0010, 22};
        vt[6] = '{1600, MAC,   16'h0800, 1'b0, 4'b0100, 1500};
        vt[7] = '{100,  MAC,   16'h0806, 1'b0, 4'b0000, 82};
        vt[8] = '{10,   MAC,   16'h0800, 1'b0, 4'b0010, 0};

        Rst_N = 1'b0; Crs_Dv = 1'b0; Rxd = 2'b00;
        repeat (3) step();
        chk_all_zero("reset");
        Rst_N = 1'b1;
        repeat (5) step();

        for (int i = 0; i < 9; i++) run_vec(i);

        // Truncated preamble must vanish without a trace.
        crst0 = n_crst; done0 = n_done;
        drive_preamble(20);
        Crs_Dv = 1'b0; Rxd = 2'b00;
        repeat (40) step();
        chk("short_pre_crc_rst", 48'(n_crst), 48'(crst0));
        chk("short_pre_done", 48'(n_done), 48'(done0));
        run_vec(0);

        // Asynchronous reset in the middle of a payload.
        mon_en = 1'b0;
        build(64, MAC, 16'h0800, 1'b0, 3);
        drive_preamble(31);
        Rxd = 2'b11; step();
        drive_bytes(30);
        Rst_N = 1'b0;
        #1;
        chk_all_zero("midrst");
        Crs_Dv = 1'b0; Rxd = 2'b00;
        repeat (3) step();
        Rst_N = 1'b1;
        pay_q.delete();
        mon_en = 1'b1;
        repeat (5) step();
        run_vec(7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
Parametrised RMII receive-frame controller. It detects the preamble/SFD on the dibit stream and enables the external dibit-to-byte assembler. It parses the assembled bytes (destination MAC, source MAC, EtherType) and filters frames by MAC and EtherType. A 4-byte delay line strips the FCS before bytes reach the external CRC engine and the payload sink. It compares the received FCS against the computed CRC, enforces min/max frame length, and reports per-frame status to the downstream RX FIFO writer.

Parameters:
pPreamble_Dibits, 31, number of consecutive 2'b01 dibits required before the 2'b11 SFD dibit
pMAC_Addr, 48'h02_00_00_00_00_01, local unicast MAC, first-received byte in [47:40]
pPromisc, 0, 1 = accept any destination MAC
pAccept_Bcast, 1, 1 = also accept FF:FF:FF:FF:FF:FF
pNum_Types, 2, number of accepted EtherTypes; 0 = accept all
pLen_Types, {16'h0800,16'h0806}, packed 16*pNum_Types accepted EtherType list, entry 0 in LSBs
pMin_Frame_Bytes, 64, minimum frame length including FCS
pMax_Frame_Bytes, 1518, maximum frame length including FCS
pCrc_Latency, 1, cycles from the last Crc_Byte_Vld until Crc_Computed is final

Ports:
Clk  in  1  system clock (RMII 50 MHz)
Rst_N  in  1  asynchronous active-low reset
Crs_Dv  in  1  RMII carrier sense / data valid
Rxd  in  2  RMII receive dibit
Byte_Rdy  in  1  one-cycle strobe, Byte valid
Byte  in  8  assembled byte from the dibit assembler
Crc_Computed  in  32  running CRC from the external engine
Rx_En  out  1  enables the dibit assembler
Crc_Rst  out  1  one-cycle pulse that clears the CRC engine at frame start
Crc_Byte_Vld  out  1  delayed byte strobe to the CRC engine
Crc_Byte  out  8  delayed byte to the CRC engine
Payload_Vld  out  1  payload byte strobe
Payload_Byte  out  8  payload byte, FCS excluded
Len_Type  out  16  parsed EtherType; valid from the first Payload_Vld until the next Crc_Rst
Frame_Done  out  1  one-cycle end-of-frame pulse
Frame_Good  out  1  qualifies Frame_Done; 1 when Frame_Status == 0
Frame_Status  out  4  [0] crc_err, [1] runt, [2] giant, [3] filtered
Frame_Bytes  out  16  total received bytes including FCS, valid with Frame_Done

Behaviour:
- Reset (async, Rst_N = 0): all outputs 0, both FSMs in their idle states, counters 0, delay line empty.
- Rx FSM, states RX_IDLE / RX_PREAMBLE / RX_DATA:
  - RX_IDLE -> RX_PREAMBLE on Crs_Dv & Rxd == 01; dibit count = 1.
  - RX_PREAMBLE: each 01 increments the count. Rxd == 11 with count == pPreamble_Dibits and Crs_Dv -> RX_DATA, Rx_En <= 1, Crc_Rst pulses. Any other dibit, or Crs_Dv low -> RX_IDLE silently, no Frame_Done.
  - RX_DATA: ~Crs_Dv -> Rx_En <= 0 and signal end-of-frame to the byte FSM on the same cycle -> RX_IDLE.
- Byte count: increments on every Byte_Rdy in RX_DATA. It saturates at 16'hFFFF and is reported as Frame_Bytes.
- Delay line: 4-deep byte shift register loaded on Byte_Rdy.
  - Once it holds 4 bytes, each new Byte_Rdy emits the oldest byte as Crc_Byte/Crc_Byte_Vld one cycle later.
  - The FCS therefore never reaches the CRC engine.
  - At end-of-frame the 4 held bytes form rCrc_Recv = {b3,b2,b1,b0} (b0 received first).
- Byte FSM, states IDLE / DEST_ADDR / SRC_ADDR / LEN_TYPE / PAYLOAD / DROP / CHECK:
  - Headers are parsed on the undelayed Byte.
  - DEST_ADDR: 6 bytes, compared on the 6th. Fail (not local, not accepted broadcast, not pPromisc) -> DROP, filtered = 1.
  - SRC_ADDR: 6 bytes, discarded.
  - LEN_TYPE: 2 bytes, big-endian into Len_Type. No match against pLen_Types (when pNum_Types > 0) -> DROP, filtered = 1.
  - PAYLOAD: delayed bytes with index >= 14 are copied to Payload_Byte/Payload_Vld, coincident with Crc_Byte_Vld.
  - DROP: Payload_Vld stays 0; Crc_Byte_Vld keeps running; waits for end-of-frame.
  - Byte count exceeding pMax_Frame_Bytes in any state -> giant = 1, DROP.
  - End-of-frame in any non-IDLE state -> CHECK.
- CHECK:
  - Waits pCrc_Latency cycles.
  - crc_err = (rCrc_Recv != Crc_Computed) | (Frame_Bytes < 4).
  - runt = Frame_Bytes < pMin_Frame_Bytes.
  - Then pulses Frame_Done with Frame_Status, Frame_Good and Frame_Bytes -> IDLE.
- End of frame during the header (bytes < 14) -> runt; filtered stays as computed so far.
- A preamble start while CHECK is pending is held in RX_PREAMBLE. Crc_Rst is never issued before Frame_Done.
- Byte_Rdy outside RX_DATA is ignored.

Decomposition:
- Shared package eth_pkg: Rx FSM and byte FSM state encodings, Frame_Status bit indices, the header byte counts (6, 6, 2), and the FCS length (4).
- One sub-module, eth_rx_fcs_delay: the 4-byte delay line. It exposes the delayed strobe/byte, a fill count, and the 32-bit held FCS.

Test Plan:
- 64-byte frame to pMAC_Addr, EtherType 0x0800, correct FCS -> 46 Payload_Vld, Frame_Done with Frame_Good = 1, Frame_Status = 0, Frame_Bytes = 64.
- Same frame with FCS byte 0 flipped -> Frame_Status = 4'b0001, Frame_Good = 0; payload still emitted.
- Destination 02:00:00:00:00:02, pPromisc = 0 -> no Payload_Vld, Frame_Status = 4'b1000; Crc_Byte_Vld still asserted 60 times.
- 40-byte frame with correct CRC -> Frame_Status = 4'b0010; 1600-byte frame -> bit [2] set, Payload_Vld stops after byte 1518.
- Preamble of 20 dibits followed by Crs_Dv low -> no Crc_Rst, no Frame_Done; a following valid frame is received Good.
- Rst_N low mid-payload -> all outputs 0 immediately; next frame is parsed correctly from its preamble.
